// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, PEND} fetch_state_e;

  typedef enum logic [1:0] {SelHold, SelInc, SelBranch, SelPend} next_sel_e;

  // Fetch addresses are word aligned; low bits of any target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, decode/execute controls and IF_ID outputs.
interface pc_fetch_unit_if;
  import fetch_pkg::*;

  logic [PC_W-1:0] iaddr;
  logic            imemReq;
  logic [PC_W-1:0] imemData;
  logic            imemReady;
  logic            stall;
  logic            branchTaken;
  logic [PC_W-1:0] branchTarget;
  logic [PC_W-1:0] ibus;
  logic [PC_W-1:0] pcPlus4Val;
  logic            fetchValid;

  modport master (
    output iaddr, imemReq, ibus, pcPlus4Val, fetchValid,
    input  imemData, imemReady, stall, branchTaken, branchTarget
  );

  modport slave (
    input  iaddr, imemReq, ibus, pcPlus4Val, fetchValid,
    output imemData, imemReady, stall, branchTaken, branchTarget
  );

endinterface

// File: rtl/pc_fetch_unit_next_pc.sv
// Combinational next-pc priority mux for the fetch stage.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  next_sel_e       sel,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] pend_target,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (sel)
      SelHold:   next_pc = pc;
      SelInc:    next_pc = pc + 32'd4;
      SelBranch: next_pc = align_pc(branch_target);
      SelPend:   next_pc = pend_target;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the pc, handshakes with imem and feeds IF_ID.
// Define FETCH_DELAY_SLOT_EN to deliver the word fetched alongside a redirect.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  next_sel_e       sel;
  logic            req;
  logic            deliver;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    sel     = SelHold;
    req     = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req     = 1'b1;
        deliver = bus.imemReady & ~bus.stall;
`ifndef FETCH_DELAY_SLOT_EN
        if (bus.branchTaken) deliver = 1'b0;
`endif
        if (bus.branchTaken & (bus.imemReady | ~req)) begin
          sel = SelBranch;
        end else if (bus.branchTaken) begin
          pend_d  = align_pc(bus.branchTarget);
          state_d = PEND;
        end else if (bus.stall | ~bus.imemReady) begin
          sel = SelHold;
        end else begin
          sel = SelInc;
        end
      end
      PEND: begin
        req = 1'b1;
        if (bus.branchTaken) pend_d = align_pc(bus.branchTarget);
`ifdef FETCH_DELAY_SLOT_EN
        // The completing word is the delay slot, so a stall must hold it here.
        if (bus.imemReady & ~bus.stall) begin
          deliver = 1'b1;
`else
        if (bus.imemReady) begin
`endif
          sel     = bus.branchTaken ? SelBranch : SelPend;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_next_pc u_next_pc (
    .sel           (sel),
    .pc            (pc_q),
    .branch_target (bus.branchTarget),
    .pend_target   (pend_q),
    .next_pc       (pc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.iaddr      = pc_q;
  assign bus.imemReq    = req;
  assign bus.pcPlus4Val = pc_q + 32'd4;
  assign bus.fetchValid = deliver;
  assign bus.ibus       = deliver ? bus.imemData : NOP_INSTR;

endmodule
